// File: rtl/axis_adder_stream.sv
// axis_adder_stream
//   Joins two AXI-Stream operand channels (A, B), adds each accepted pair and
//   queues {carry,sum} in a DEPTH-entry buffer. Sum and carry leave on two
//   independent AXI-Stream master channels, each with its own read pointer,
//   so either consumer may stall without blocking the other until the queue
//   fills.
//
//   Parameters : WIDTH (operand/sum bits, >=1), DEPTH (queue entries, pow2 >=2)
//   Ports      : clk, reset (sync, active low)
//                s_a_*   operand A slave  (tvalid, tdata, tready)
//                s_b_*   operand B slave  (tvalid, tdata, tready)
//                m_sum_*   sum master     (tvalid, tdata[WIDTH], tready)
//                m_carry_* carry master   (tvalid, tdata[1], tready)
//   Option     : ADDER_TLAST_EN adds s_a_tlast, s_b_tlast, m_sum_tlast,
//                m_carry_tlast and chains carry across the beats of a packet
//                (LSB beat first, carry-in cleared after a last beat).
module axis_adder_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ADDER_TLAST_EN
  input  logic             s_a_tlast,
  input  logic             s_b_tlast,
  output logic             m_sum_tlast,
  output logic             m_carry_tlast,
`endif
  input  logic             s_a_tvalid,
  input  logic [WIDTH-1:0] s_a_tdata,
  output logic             s_a_tready,
  input  logic             s_b_tvalid,
  input  logic [WIDTH-1:0] s_b_tdata,
  output logic             s_b_tready,
  output logic             m_sum_tvalid,
  output logic [WIDTH-1:0] m_sum_tdata,
  input  logic             m_sum_tready,
  output logic             m_carry_tvalid,
  output logic             m_carry_tdata,
  input  logic             m_carry_tready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
`ifdef ADDER_TLAST_EN
  localparam int EW = WIDTH + 2;   // {last, carry, sum}
`else
  localparam int EW = WIDTH + 1;   // {carry, sum}
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_sum_q, rd_sum_d;
  logic [PW-1:0] rd_carry_q, rd_carry_d;
  logic [PW-1:0] cnt_sum, cnt_carry;
  logic          full;
  logic          accept, sum_pop, carry_pop;
  logic          cin;
  logic [WIDTH:0] add_res;
  logic [EW-1:0] wr_entry;
  logic [PW-1:0] sum_ptr, carry_ptr;
  logic [EW-1:0] sum_ent, carry_ent;

  assign cnt_sum   = wr_q - rd_sum_q;
  assign cnt_carry = wr_q - rd_carry_q;
  // Slot is reusable only once both channels have popped it, so the slower
  // reader sets the fill level.
  assign full = (cnt_sum == PW'(DEPTH)) || (cnt_carry == PW'(DEPTH));

  // Readies come from registered state only; a pop in the same cycle does
  // not open a slot for a write while full.
  assign s_a_tready = reset && s_b_tvalid && !full;
  assign s_b_tready = reset && s_a_tvalid && !full;
  assign accept     = s_a_tvalid && s_a_tready;

  assign add_res = {1'b0, s_a_tdata} + {1'b0, s_b_tdata} + {{WIDTH{1'b0}}, cin};

`ifdef ADDER_TLAST_EN
  logic cin_q, cin_d;
  logic beat_last;
  assign beat_last = s_a_tlast | s_b_tlast;
  assign cin       = cin_q;
  assign wr_entry  = {beat_last, add_res};

  always_comb begin
    cin_d = cin_q;
    if (accept) cin_d = beat_last ? 1'b0 : add_res[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset) cin_q <= 1'b0;
    else        cin_q <= cin_d;
  end
`else
  assign cin      = 1'b0;
  assign wr_entry = add_res;
`endif

  assign m_sum_tvalid   = (cnt_sum != '0);
  assign m_carry_tvalid = (cnt_carry != '0);
  assign sum_pop        = m_sum_tvalid && m_sum_tready;
  assign carry_pop      = m_carry_tvalid && m_carry_tready;

  // When a channel is empty its wr == rd, so slot rd-1 is the last entry it
  // popped and cannot be rewritten until wr moves (which makes it non-empty).
  // Showing that slot keeps data stable at the last popped value; after reset
  // the cleared storage makes it read 0.
  assign sum_ptr   = (cnt_sum   == '0) ? rd_sum_q   - PW'(1) : rd_sum_q;
  assign carry_ptr = (cnt_carry == '0) ? rd_carry_q - PW'(1) : rd_carry_q;
  assign sum_ent   = mem_q[sum_ptr[AW-1:0]];
  assign carry_ent = mem_q[carry_ptr[AW-1:0]];

  assign m_sum_tdata   = sum_ent[WIDTH-1:0];
  assign m_carry_tdata = carry_ent[WIDTH];
`ifdef ADDER_TLAST_EN
  assign m_sum_tlast   = sum_ent[WIDTH+1];
  assign m_carry_tlast = carry_ent[WIDTH+1];
`endif

  always_comb begin
    wr_d       = wr_q;
    rd_sum_d   = rd_sum_q;
    rd_carry_d = rd_carry_q;
    if (accept)    wr_d       = wr_q + PW'(1);
    if (sum_pop)   rd_sum_d   = rd_sum_q + PW'(1);
    if (carry_pop) rd_carry_d = rd_carry_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q       <= '0;
      rd_sum_q   <= '0;
      rd_carry_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_sum_q   <= rd_sum_d;
      rd_carry_q <= rd_carry_d;
      if (accept) mem_q[wr_q[AW-1:0]] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_axis_adder_stream.sv
module tb_axis_adder_stream;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_a_tvalid, s_b_tvalid, s_a_tready, s_b_tready;
  logic [W-1:0] s_a_tdata, s_b_tdata;
  logic         m_sum_tvalid, m_sum_tready, m_carry_tvalid, m_carry_tready;
  logic [W-1:0] m_sum_tdata;
  logic         m_carry_tdata;
`ifdef ADDER_TLAST_EN
  logic         s_a_tlast, s_b_tlast, m_sum_tlast, m_carry_tlast;
`endif

  axis_adder_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
`ifdef ADDER_TLAST_EN
    .s_a_tlast(s_a_tlast), .s_b_tlast(s_b_tlast),
    .m_sum_tlast(m_sum_tlast), .m_carry_tlast(m_carry_tlast),
`endif
    .s_a_tvalid(s_a_tvalid), .s_a_tdata(s_a_tdata), .s_a_tready(s_a_tready),
    .s_b_tvalid(s_b_tvalid), .s_b_tdata(s_b_tdata), .s_b_tready(s_b_tready),
    .m_sum_tvalid(m_sum_tvalid), .m_sum_tdata(m_sum_tdata), .m_sum_tready(m_sum_tready),
    .m_carry_tvalid(m_carry_tvalid), .m_carry_tdata(m_carry_tdata), .m_carry_tready(m_carry_tready)
  );

  always #5 clk = ~clk;

  typedef struct { int v; bit l; } ent_t;
  ent_t sq[$];
  ent_t cq[$];
  int   last_sum, last_carry, cin_m;
  int   checks = 0, fails = 0;
  bit   run = 0, acc_flag = 0, stop_rdy = 0;
  bit   cur_last = 0;

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", n, act, exp, $time);
    end
  endfunction

  // Scoreboard/monitor: samples mid-cycle, compares against the model, then
  // advances the model by whatever the next rising edge will do.
  always @(negedge clk) if (run) begin
    bit   room;
    ent_t e;
    int   t;
    room = reset && (sq.size() < D) && (cq.size() < D);
    chk("s_a_tready", s_a_tready, room && s_b_tvalid);
    chk("s_b_tready", s_b_tready, room && s_a_tvalid);
    chk("sum_valid", m_sum_tvalid, sq.size() != 0);
    chk("carry_valid", m_carry_tvalid, cq.size() != 0);
    chk("sum_data", m_sum_tdata, sq.size() != 0 ? sq[0].v : last_sum);
    chk("carry_data", m_carry_tdata, cq.size() != 0 ? cq[0].v : last_carry);
`ifdef ADDER_TLAST_EN
    if (sq.size() != 0) chk("sum_tlast", m_sum_tlast, sq[0].l);
    if (cq.size() != 0) chk("carry_tlast", m_carry_tlast, cq[0].l);
`endif
    acc_flag = room && s_a_tvalid && s_b_tvalid;
    if (!reset) begin
      sq.delete(); cq.delete();
      last_sum = 0; last_carry = 0; cin_m = 0;
    end else begin
      if (m_sum_tready && sq.size() != 0)   last_sum   = sq.pop_front().v;
      if (m_carry_tready && cq.size() != 0) last_carry = cq.pop_front().v;
      if (acc_flag) begin
        t = int'(s_a_tdata) + int'(s_b_tdata) + cin_m;
`ifdef ADDER_TLAST_EN
        e.l = s_a_tlast | s_b_tlast;
        cin_m = e.l ? 0 : t / (1 << W);
`else
        e.l = 0;
`endif
        e.v = t % (1 << W); sq.push_back(e);
        e.v = t / (1 << W); cq.push_back(e);
      end
    end
  end

  task automatic push(input int a, input int b, input bit l);
    int n = 0;
    s_a_tvalid = 1; s_b_tvalid = 1;
    s_a_tdata = W'(a); s_b_tdata = W'(b);
    cur_last = l;
`ifdef ADDER_TLAST_EN
    s_a_tlast = l; s_b_tlast = 0;
`endif
    do begin @(posedge clk); n++; end while (!acc_flag && n < 100);
    if (!acc_flag) begin fails++; $display("FAIL push_timeout a=%0d b=%0d", a, b); end
    #1; s_a_tvalid = 0; s_b_tvalid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    void'($urandom(32'd2024));
    reset = 0; s_a_tvalid = 1; s_b_tvalid = 1; s_a_tdata = 8'h11; s_b_tdata = 8'h22;
    m_sum_tready = 1; m_carry_tready = 1;
    last_sum = 0; last_carry = 0; cin_m = 0;
`ifdef ADDER_TLAST_EN
    s_a_tlast = 0; s_b_tlast = 0;
`endif
    @(posedge clk); #1; run = 1;
    idle(1);
    s_a_tvalid = 0; s_b_tvalid = 0;
    idle(1);
    reset = 1;
    idle(1);

    // basic add: 200+100 -> 0x2C carry 1
    push(200, 100, 0);
    idle(3);

    // join: lone A for 3 cycles consumes nothing
    s_a_tvalid = 1; s_a_tdata = 8'h05;
    idle(3);
    push(5, 3, 0);
    idle(3);

    // split backpressure: sums stalled, carries drain
    m_sum_tready = 0; m_carry_tready = 1;
    fork
      begin for (int i = 1; i <= 5; i++) push(i, i, 0); end
      begin idle(12); m_sum_tready = 1; end
    join
    idle(4);

    // reset with three results queued
    m_sum_tready = 0; m_carry_tready = 0;
    for (int i = 0; i < 3; i++) push(10 + i, 20 + i, 0);
    reset = 0; idle(1); reset = 1;
    push(7, 9, 0);
    idle(1);
    m_sum_tready = 1; m_carry_tready = 1;
    idle(3);

`ifdef ADDER_TLAST_EN
    // two-beat packet 0x01FF + 0x0001, then a fresh packet
    push(8'hFF, 8'h01, 0);
    push(8'h01, 8'h00, 1);
    push(8'hFF, 8'h01, 1);
    idle(3);
`endif

    // random traffic with independent random ready toggles
    stop_rdy = 0;
    fork
      begin
        for (int p = 0; p < 60; p++) begin
          int gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) begin
            s_a_tvalid = $urandom_range(0, 1); s_b_tvalid = 0;
            if (!s_a_tvalid) s_b_tvalid = $urandom_range(0, 1);
            s_a_tdata = W'($urandom); s_b_tdata = W'($urandom);
            idle(1);
          end
          push($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3) == 0);
        end
        stop_rdy = 1;
      end
      begin
        while (!stop_rdy) begin
          m_sum_tready = $urandom_range(0, 1);
          m_carry_tready = $urandom_range(0, 1);
          idle(1);
        end
      end
    join

    // drain
    m_sum_tready = 1; m_carry_tready = 1;
    for (int n = 0; n < 50 && (sq.size() != 0 || cq.size() != 0); n++) idle(1);
    idle(2);
    chk("drained", sq.size() + cq.size(), 0);
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
